// File: rtl/matrix_feeder.sv
// ============================================================================
// matrix_feeder : routes host headers/payloads into M_fifo or hashin_fifo.
// Optional build macro: MATRIX_FEEDER_STATS_EN (adds write/hash statistics).
// Revision: 1.0
// ============================================================================
`default_nettype none

module matrix_feeder (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] s_data,
    input  logic        m_full,
    output logic        m_we,
    output logic [63:0] m_wdata,
    input  logic        hashin_full,
    output logic        hashin_we,
    output logic [63:0] hashin_wdata,
    output logic        busy,
    output logic        err
`ifdef MATRIX_FEEDER_STATS_EN
    ,
    output logic [31:0] m_words_cnt,
    output logic [31:0] hash_cnt
`endif
);

    localparam logic [7:0] OP_MATRIX   = 8'h4D;
    localparam logic [7:0] OP_HASH     = 8'h48;
    localparam logic [9:0] M_LAST_WORD = 10'd1023;
    localparam logic [9:0] H_LAST_WORD = 10'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        M_LOAD = 2'd1,
        H_LOAD = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [9:0] word_cnt;
    logic [9:0] word_cnt_next;
    logic       err_next;
    logic       hash_done;

    // Write data is a pure pass-through; the enables decide who takes it.
    assign m_wdata      = s_data;
    assign hashin_wdata = s_data;
    assign busy         = (state != IDLE);

    always_comb begin
        state_next    = state;
        word_cnt_next = word_cnt;
        s_ready       = 1'b1;
        m_we          = 1'b0;
        hashin_we     = 1'b0;
        err_next      = 1'b0;
        hash_done     = 1'b0;

        case (state)
            IDLE: begin
                if (s_valid) begin
                    case (s_data[63:56])
                        OP_MATRIX: begin
                            state_next    = M_LOAD;
                            word_cnt_next = 10'd0;
                        end
                        OP_HASH: begin
                            state_next    = H_LOAD;
                            word_cnt_next = 10'd0;
                        end
                        default: err_next = 1'b1;
                    endcase
                end
            end

            M_LOAD: begin
                s_ready = !m_full;
                m_we    = s_valid && !m_full;
                if (m_we) begin
                    // 10-bit counter wraps to 0 on its own after word 1023.
                    word_cnt_next = word_cnt + 10'd1;
                    if (word_cnt == M_LAST_WORD) begin
                        state_next = IDLE;
                    end
                end
            end

            H_LOAD: begin
                s_ready   = !hashin_full;
                hashin_we = s_valid && !hashin_full;
                if (hashin_we) begin
                    if (word_cnt == H_LAST_WORD) begin
                        state_next    = IDLE;
                        word_cnt_next = 10'd0;
                        hash_done     = 1'b1;
                    end else begin
                        word_cnt_next = word_cnt + 10'd1;
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                word_cnt_next = 10'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= 10'd0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            word_cnt <= word_cnt_next;
            err      <= err_next;
        end
    end

`ifdef MATRIX_FEEDER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_words_cnt <= 32'd0;
            hash_cnt    <= 32'd0;
        end else begin
            if (m_we) begin
                m_words_cnt <= m_words_cnt + 32'd1;
            end
            if (hash_done) begin
                hash_cnt <= hash_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_hash_done;
    assign unused_hash_done = hash_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_feeder.sv
// Scoreboard bench for matrix_feeder: driver queues expected FIFO writes,
// a negedge monitor tracks the transfer protocol and pops on every write.
`default_nettype none

module tb_matrix_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [63:0] s_data = 64'd0;
    logic        m_full = 1'b0;
    logic        hashin_full = 1'b0;
    logic        s_ready;
    logic        m_we;
    logic [63:0] m_wdata;
    logic        hashin_we;
    logic [63:0] hashin_wdata;
    logic        busy;
    logic        err;
`ifdef MATRIX_FEEDER_STATS_EN
    logic [31:0] m_words_cnt;
    logic [31:0] hash_cnt;
`endif

    matrix_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_full       (m_full),
        .m_we         (m_we),
        .m_wdata      (m_wdata),
        .hashin_full  (hashin_full),
        .hashin_we    (hashin_we),
        .hashin_wdata (hashin_wdata),
        .busy         (busy),
        .err          (err)
`ifdef MATRIX_FEEDER_STATS_EN
        ,
        .m_words_cnt  (m_words_cnt),
        .hash_cnt     (hash_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [64:0] sb[$];          // {is_matrix, data}
    bit          rand_full = 1'b0;

    // Reference model: destination (0 none, 1 matrix, 2 hash) and words left.
    int          mdl_dest = 0;
    int          mdl_left = 0;
    bit          exp_err = 1'b0;
    int unsigned mdl_mwords = 0;
    int unsigned mdl_hashes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rand_full) begin
            m_full      = ($urandom_range(0, 3) == 0);
            hashin_full = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: outputs are stable mid-cycle, the model steps once per cycle.
    always @(negedge clk) begin
        logic        exp_ready;
        logic        exp_err_n;
        logic [64:0] e;
        if (rst) begin
            check("rst_s_ready", s_ready, 1);
            check("rst_busy", busy, 0);
            check("rst_m_we", m_we, 0);
            check("rst_hashin_we", hashin_we, 0);
            check("rst_err", err, 0);
            mdl_dest   = 0;
            mdl_left   = 0;
            exp_err    = 1'b0;
            mdl_mwords = 0;
            mdl_hashes = 0;
        end else begin
            exp_ready = (mdl_dest == 0) ? 1'b1 : (mdl_dest == 1) ? !m_full : !hashin_full;
            check("s_ready", s_ready, exp_ready);
            check("busy", busy, mdl_dest != 0);
            check("err", err, exp_err);
            check("m_we", m_we, (mdl_dest == 1) && s_valid && !m_full);
            check("hashin_we", hashin_we, (mdl_dest == 2) && s_valid && !hashin_full);
            if (m_we && hashin_we) check("we_exclusive", 1, 0);
`ifdef MATRIX_FEEDER_STATS_EN
            check("m_words_cnt", m_words_cnt, mdl_mwords);
            check("hash_cnt", hash_cnt, mdl_hashes);
`endif
            if (m_we || hashin_we) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", {63'd0, m_we}, {63'd0, hashin_we} + 64'd2);
                end else begin
                    e = sb.pop_front();
                    check("write_dest_is_m", m_we, e[64]);
                    check("write_data", m_we ? m_wdata : hashin_wdata, e[63:0]);
                end
            end
            exp_err_n = (mdl_dest == 0) && s_valid &&
                        (s_data[63:56] != 8'h4D) && (s_data[63:56] != 8'h48);
            if (s_valid && exp_ready) begin
                if (mdl_dest == 0) begin
                    if (s_data[63:56] == 8'h4D) begin
                        mdl_dest = 1;
                        mdl_left = 1024;
                    end else if (s_data[63:56] == 8'h48) begin
                        mdl_dest = 2;
                        mdl_left = 4;
                    end
                end else begin
                    if (mdl_dest == 1) mdl_mwords++;
                    mdl_left--;
                    if (mdl_left == 0) begin
                        if (mdl_dest == 2) mdl_hashes++;
                        mdl_dest = 0;
                    end
                end
            end
            exp_err = exp_err_n;
        end
    end

    task automatic xfer(input logic [63:0] d);
        int waitc = 0;
        s_valid = 1'b1;
        s_data  = d;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waitc++;
            if (waitc > 500) begin
                n_cmp++;
                n_bad++;
                $display("FAIL xfer_timeout: s_ready stuck 0, data %h", d);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
    endtask

    task automatic gap();
        if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic header(input logic [7:0] op);
        logic [63:0] r;
        r = {$urandom, $urandom};
        xfer({op, r[55:0]});
    endtask

    task automatic payload(input bit is_m, input int n);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom};
            sb.push_back({is_m, d});
            xfer(d);
            gap();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Hash load without back-pressure, then an illegal header followed by a hash.
        header(8'h48);
        payload(1'b0, 4);
        header(8'h00);
        header(8'h48);
        payload(1'b0, 4);

        // Matrix load with random back-pressure and valid gaps.
        rand_full = 1'b1;
        header(8'h4D);
        payload(1'b1, 1024);
        rand_full = 1'b0;
        m_full = 1'b0;
        hashin_full = 1'b0;

        // Header accepted while the hash FIFO is full; payload waits for it to drain.
        hashin_full = 1'b1;
        m_full = 1'b1;
        header(8'h48);
        m_full = 1'b0;
        fork
            payload(1'b0, 4);
            begin
                repeat (6) @(posedge clk);
                #1;
                hashin_full = 1'b0;
            end
        join

        // Abandon a matrix payload with reset, then run a full one.
        header(8'h4D);
        payload(1'b1, 500);
        s_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_m_we", m_we, 0);
        sb.delete();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst = 1'b0;
        header(8'h4D);
        payload(1'b1, 1024);

        // Random mix of hash and illegal headers under random back-pressure.
        rand_full = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                header(8'h48);
                payload(1'b0, 4);
            end else begin
                header(8'($urandom_range(0, 255)) == 8'h4D ? 8'h01 :
                       8'($urandom_range(0, 255)) == 8'h48 ? 8'h02 : 8'hC3);
            end
            gap();
        end
        rand_full = 1'b0;
        m_full = 1'b0;
        hashin_full = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
